// File: rtl/fir_decim_out.sv
// Decimating output buffer for the 16-tap FIR: keeps every DECIM-th qualified
// sample and queues it in a small FIFO drained by a valid/ready handshake.
module fir_decim_out #(
  parameter int DECIM = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [10:0]              din,
  input  logic                     din_en,
  output logic [10:0]              dout,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  output logic                     ovf,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [PW-1:0] PHASE_LAST = PW'(DECIM - 1);
  localparam logic [AW:0]   LEVEL_FULL = (AW+1)'(DEPTH);

  logic [PW-1:0] phase_q, phase_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          ovf_q, ovf_d;
  logic [10:0]   mem_q [DEPTH];
  logic [10:0]   mem_d [DEPTH];

  logic keep;
  logic full;
  logic pop;
  logic push;

  // A full FIFO still accepts a kept sample when the head leaves in the same cycle.
  always_comb begin
    keep  = din_en && (phase_q == '0);
    full  = (level_q == LEVEL_FULL);
    pop   = (level_q != '0) && dout_ready;
    push  = keep && (!full || pop);

    phase_d = phase_q;
    if (din_en) begin
      phase_d = (phase_q == PHASE_LAST) ? '0 : phase_q + PW'(1);
    end

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + (AW+1)'(1);
    end else if (pop && !push) begin
      level_d = level_q - (AW+1)'(1);
    end

    ovf_d = ovf_q | (keep && full && !pop);

    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      phase_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      phase_q  <= phase_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      mem_q    <= mem_d;
    end
  end

  assign dout       = mem_q[rd_ptr_q];
  assign dout_valid = (level_q != '0);
  assign ovf        = ovf_q;
  assign level      = level_q;

endmodule

// File: doc/fir_decim_out.md
# fir_decim_out

Output decimation and buffering stage placed directly downstream of the synchronous 16-tap FIR filter. Takes the filter's 11-bit signed output, keeps one sample in every DECIM qualified samples, and buffers the kept samples in a small FIFO. The FIFO drains through a valid/ready handshake to the consumer. Drops caused by a full FIFO are flagged with a sticky overflow bit.

## Interface

Parameters:
- DECIM, default 4: decimation ratio, range 1..16. DECIM=1 keeps every qualified sample.
- DEPTH, default 4: FIFO depth in samples. Power of two, range 2..16.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-low reset. Sampled on the rising edge of clk; 0 = reset.
- din  input  11  signed sample from the FIR output (dout of the filter).
- din_en  input  1  qualifier; 1 = din is a new sample this cycle.
- dout  output  11  signed head-of-FIFO sample.
- dout_valid  output  1  1 = FIFO non-empty and dout is meaningful.
- dout_ready  input  1  consumer accepts dout this cycle.
- ovf  output  1  sticky overflow; set when a kept sample is dropped.
- level  output  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.

## Operation

- **Phase counter.** Range 0..DECIM-1. Increments by one (wrapping to 0) on every cycle with din_en=1. Holds when din_en=0.
- **Keep rule.** A sample is kept when din_en=1 and phase==0.
  - The first qualified sample after reset is kept.
  - After that, samples 0, DECIM, 2·DECIM, … are kept.
- **Push and pop.**
  - Push = keep. Write din to mem[wr_ptr], then wr_ptr+1 modulo DEPTH.
  - Pop = dout_valid & dout_ready. Advance rd_ptr modulo DEPTH.
- **Occupancy.** level +1 on push only, −1 on pop only, unchanged on both or neither.
- **Full FIFO (level==DEPTH):**
  - Push with no pop: sample discarded, pointers and level unchanged, ovf←1.
  - Push with pop in the same cycle: both succeed, level stays DEPTH, ovf unchanged.
- **Empty FIFO (level==0):**
  - dout_valid=0 and dout_ready is ignored; there is no pop and no underflow.
  - Push while empty makes dout_valid=1 on the next cycle.
- **Sticky flag.** ovf clears only on reset.
- **Data path.** Pure storage: no arithmetic on din, bit-exact pass-through, sign preserved.
- **Output drive.** dout = mem[rd_ptr], combinationally from the registered pointer and memory. dout_valid = (level!=0).
- **Reset (rst=0 at a clock edge):**
  - phase, wr_ptr, rd_ptr, level, ovf all ←0; all memory entries ←0.
  - Consequently dout=0 and dout_valid=0 after reset.
  - Reset overrides any simultaneous din_en or dout_ready.
  - Reset mid-stream discards buffered samples; the phase restarts so the first qualified sample after reset release is kept.

## Timing

- Latency from din/din_en (kept, FIFO empty) to dout/dout_valid: 1 cycle. Sampled at edge k, visible after edge k, consumable at edge k+1.
- Pop takes effect at the edge where dout_valid & dout_ready are both 1. The next entry, or dout_valid=0, is visible after that edge.
- Throughput: one push and one pop per cycle, sustained.
- dout_valid never deasserts while unpopped data remains. dout is stable while dout_valid=1 and dout_ready=0.
- No combinational path from dout_ready to dout_valid or dout beyond the pointer registers.
- level and ovf are registered and reflect the state after the last edge.

## Test plan

- **Reset values.** Hold rst=0 for 3 cycles with din_en=1 and din=300. Required: dout=0, dout_valid=0, level=0, ovf=0 throughout.
- **Decimation.** DECIM=4, DEPTH=4, dout_ready=1. Apply din_en=1 continuously with din = 1,2,3,…,12. Required: dout sequence 1,5,9, each valid for exactly one cycle, starting one cycle after its input.
- **Gapped qualifier and sign.** DECIM=2. Apply din_en pattern 1,0,1,1,0,1 with din = −1024, x, 7, −5, x, 1023. Required: kept samples −1024 and −5, bit-exact.
- **Fill to full, then overflow.** DECIM=1, DEPTH=4, dout_ready=0. Push 10,20,30,40,50. Required:
  - level reaches 4; 50 is dropped and ovf=1.
  - With dout_ready=1, drains 10,20,30,40, then dout_valid=0.
  - ovf stays 1.
- **Simultaneous push and pop while full.** With level=4, dout_ready=1 and din_en=1 (din=99) in one cycle. Required: level stays 4, ovf stays 0, and 99 is output last.
- **Mid-stream reset.** DECIM=3, two samples buffered, phase=2. Pulse rst=0 for 1 cycle. Required:
  - level=0, dout_valid=0, ovf=0.
  - The next qualified din is kept and appears on dout one cycle later.
